// File: rtl/ram_seq_ctrl.sv
// rtl/ram_seq_ctrl.sv - command sequencer driving a 32x4 RAM: single writes, block fills, pipelined scans/verifies
module ram_seq_ctrl #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 4,
  parameter int RD_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  input  logic [DATA_W-1:0] pattern,
  input  logic              incr,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q,
  output logic              rd_valid,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [5:0]        err_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_FILL,
    S_ISSUE,
    S_DRAIN,
    S_FINISH
  } state_t;

  state_t state, state_n;

  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] word_r;
  logic [ADDR_W:0]   remain_r;
  logic              incr_r;
  logic              verify_r;
  logic              last;

  // One tag per issued read, aligned with the RAM read latency
  logic [RD_LAT-1:0] tag_valid;
  logic [ADDR_W-1:0] tag_addr [RD_LAT];
  logic [DATA_W-1:0] tag_exp  [RD_LAT];

  assign last        = (remain_r == {{ADDR_W{1'b0}}, 1'b1});
  assign ram_address = addr_r;
  assign ram_data    = word_r;
  assign ram_wren    = (state == S_WRITE) || (state == S_FILL);
  assign busy        = (state == S_WRITE) || (state == S_FILL) ||
                       (state == S_ISSUE) || (state == S_DRAIN);
  assign done        = (state == S_FINISH);

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          case (op)
            2'b00:   state_n = S_WRITE;
            2'b01:   state_n = S_FILL;
            default: state_n = S_ISSUE;
          endcase
        end
      end
      S_WRITE:  state_n = S_FINISH;
      S_FILL:   if (last) state_n = S_FINISH;
      S_ISSUE:  if (last) state_n = S_DRAIN;
      S_DRAIN:  if (tag_valid == '0) state_n = S_FINISH;
      S_FINISH: state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      addr_r    <= '0;
      word_r    <= '0;
      remain_r  <= '0;
      incr_r    <= 1'b0;
      verify_r  <= 1'b0;
      tag_valid <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        tag_addr[i] <= '0;
        tag_exp[i]  <= '0;
      end
      rd_valid  <= 1'b0;
      rd_addr   <= '0;
      rd_data   <= '0;
      err_count <= '0;
    end else begin
      if ((state == S_FILL || state == S_ISSUE) && !last) begin
        addr_r   <= addr_r + 1'b1;
        word_r   <= word_r + {{(DATA_W-1){1'b0}}, incr_r};
        remain_r <= remain_r - 1'b1;
      end

      tag_valid[0] <= (state == S_ISSUE);
      tag_addr[0]  <= addr_r;
      tag_exp[0]   <= word_r;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_addr[i]  <= tag_addr[i-1];
        tag_exp[i]   <= tag_exp[i-1];
      end

      rd_valid <= tag_valid[RD_LAT-1];
      if (tag_valid[RD_LAT-1]) begin
        rd_addr <= tag_addr[RD_LAT-1];
        rd_data <= ram_q;
        if (verify_r && (ram_q != tag_exp[RD_LAT-1])) begin
          err_count <= err_count + 1'b1;
        end
      end

      if (state == S_IDLE && start) begin
        addr_r    <= base_addr;
        word_r    <= pattern;
        incr_r    <= incr;
        verify_r  <= (op == 2'b11);
        remain_r  <= (count == '0) ? {1'b1, {ADDR_W{1'b0}}} : count;
        err_count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ram_seq_ctrl.sv
// tb/tb_ram_seq_ctrl.sv - scoreboard bench for ram_seq_ctrl with behavioural RAM models
module tb_ram_seq_ctrl;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset, start, start2;
  logic [1:0] op;
  logic [4:0] base_addr;
  logic [5:0] count;
  logic [3:0] pattern;
  logic       incr;

  logic       busy, done, ram_wren, rd_valid;
  logic [4:0] ram_address, rd_addr;
  logic [3:0] ram_data, ram_q, rd_data;
  logic [5:0] err_count;

  logic       busy2, done2, ram_wren2, rd_valid2;
  logic [4:0] ram_address2, rd_addr2;
  logic [3:0] ram_data2, ram_q2, rd_data2, q2a;
  logic [5:0] err_count2;

  ram_seq_ctrl #(.ADDR_W(5), .DATA_W(4), .RD_LAT(1)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .base_addr(base_addr),
    .count(count), .pattern(pattern), .incr(incr), .busy(busy), .done(done),
    .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_data(rd_data), .err_count(err_count)
  );

  ram_seq_ctrl #(.ADDR_W(5), .DATA_W(4), .RD_LAT(2)) dut2 (
    .clock(clock), .reset(reset), .start(start2), .op(op), .base_addr(base_addr),
    .count(count), .pattern(pattern), .incr(incr), .busy(busy2), .done(done2),
    .ram_address(ram_address2), .ram_data(ram_data2), .ram_wren(ram_wren2), .ram_q(ram_q2),
    .rd_valid(rd_valid2), .rd_addr(rd_addr2), .rd_data(rd_data2), .err_count(err_count2)
  );

  // RAM models: one-cycle read for dut, two-cycle read for dut2
  logic [3:0] mem  [32];
  logic [3:0] mem2 [32];

  always @(posedge clock) begin
    if (ram_wren) mem[ram_address] <= ram_data;
    ram_q <= mem[ram_address];
  end

  always @(posedge clock) begin
    if (ram_wren2) mem2[ram_address2] <= ram_data2;
    q2a    <= mem2[ram_address2];
    ram_q2 <= q2a;
  end

  typedef struct packed {
    logic [4:0] a;
    logic [3:0] d;
  } ent_t;

  ent_t rq[$];
  ent_t wq[$];
  ent_t me;
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic ent_t mk(input int a, input int d);
    ent_t r;
    r.a = a[4:0];
    r.d = d[3:0];
    return r;
  endfunction

  function void check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  always @(negedge clock) begin
    if (ram_wren === 1'b1) begin
      if (wq.size() == 0) begin
        check("unexpected_write", 1, 0);
      end else begin
        me = wq.pop_front();
        check("wr_addr", int'(ram_address), int'(me.a));
        check("wr_data", int'(ram_data), int'(me.d));
      end
    end
    if (rd_valid === 1'b1) begin
      if (rq.size() == 0) begin
        check("unexpected_rd_valid", 1, 0);
      end else begin
        me = rq.pop_front();
        check("rd_addr", int'(rd_addr), int'(me.a));
        check("rd_data", int'(rd_data), int'(me.d));
      end
    end
    if (done === 1'b1) check("done_with_rd_valid", int'(rd_valid), 0);
  end

  task automatic cmd(input int which, input logic [1:0] o, input int b, input int c,
                     input int p, input logic inc);
    @(negedge clock);
    op        = o;
    base_addr = b[4:0];
    count     = c[5:0];
    pattern   = p[3:0];
    incr      = inc;
    if (which == 2) start2 = 1'b1;
    else            start  = 1'b1;
    @(posedge clock);
    #1;
    start  = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic wait_done(input string name, input int limit, output int cyc);
    cyc = 0;
    do begin
      @(negedge clock);
      cyc++;
    end while (done !== 1'b1 && cyc < limit);
    check({name, "_done_seen"}, int'(done === 1'b1), 1);
  endtask

  int cyc, nd, rv_cyc, done_cyc, rv_cnt;

  initial begin
    for (int i = 0; i < 32; i++) begin
      mem[i]  = 4'd0;
      mem2[i] = 4'((i * 3) % 16);
    end
    reset = 1'b1; start = 1'b0; start2 = 1'b0;
    op = 2'b00; base_addr = '0; count = '0; pattern = '0; incr = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_wren", int'(ram_wren), 0);
    check("rst_rd_valid", int'(rd_valid), 0);
    check("rst_err_count", int'(err_count), 0);
    check("rst_ram_address", int'(ram_address), 0);
    check("rst_busy2", int'(busy2), 0);
    check("rst_err_count2", int'(err_count2), 0);
    reset = 1'b0;

    // 32-word incrementing fill from address 0
    for (int i = 0; i < 32; i++) wq.push_back(mk(i, i % 16));
    cmd(1, 2'b01, 0, 0, 0, 1'b1);
    wait_done("fill32", 100, cyc);
    check("fill32_cycles", cyc, 33);
    check("fill32_busy_at_done", int'(busy), 0);
    @(negedge clock);
    check("fill32_done_pulse", int'(done), 0);
    check("fill32_writes_left", wq.size(), 0);

    // wrapping scan 30,31,0,1
    rq.push_back(mk(30, 14)); rq.push_back(mk(31, 15));
    rq.push_back(mk(0, 0));   rq.push_back(mk(1, 1));
    cmd(1, 2'b10, 30, 4, 0, 1'b0);
    wait_done("scan4", 100, cyc);
    check("scan4_cycles", cyc, 7);
    check("scan4_reads_left", rq.size(), 0);

    // single write then verify with one planted mismatch
    wq.push_back(mk(5, 9));
    cmd(1, 2'b00, 5, 1, 9, 1'b0);
    wait_done("write1", 20, cyc);
    check("write1_cycles", cyc, 2);
    for (int i = 0; i < 8; i++) rq.push_back(mk(i, (i == 5) ? 9 : i));
    cmd(1, 2'b11, 0, 8, 0, 1'b1);
    wait_done("verify8", 100, cyc);
    check("verify8_cycles", cyc, 11);
    check("verify8_err_count", int'(err_count), 1);
    check("verify8_reads_left", rq.size(), 0);

    // start held high with different fields during a 16-word fill
    for (int i = 0; i < 16; i++) wq.push_back(mk(16 + i, 3));
    cmd(1, 2'b01, 16, 16, 3, 1'b0);
    op = 2'b00; base_addr = 5'd0; pattern = 4'd7; incr = 1'b1; start = 1'b1;
    wait_done("fill16", 100, cyc);
    start = 1'b0;
    check("fill16_cycles", cyc, 17);
    check("fill16_writes_left", wq.size(), 0);
    @(negedge clock);
    check("fill16_idle_busy", int'(busy), 0);
    for (int i = 0; i < 16; i++) rq.push_back(mk(16 + i, 3));
    cmd(1, 2'b10, 16, 16, 0, 1'b0);
    wait_done("scan16", 100, cyc);
    check("scan16_cycles", cyc, 19);
    check("scan16_reads_left", rq.size(), 0);

    // reset after three issues of an 8-word scan
    rq.push_back(mk(0, 0));
    cmd(1, 2'b10, 0, 8, 0, 1'b0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("abort_busy", int'(busy), 0);
    check("abort_rd_valid", int'(rd_valid), 0);
    check("abort_wren", int'(ram_wren), 0);
    check("abort_done", int'(done), 0);
    reset = 1'b0;
    nd = 0;
    repeat (5) begin
      @(negedge clock);
      if (done || rd_valid || busy) nd++;
    end
    check("abort_quiet", nd, 0);
    check("abort_reads_left", rq.size(), 0);
    rq.push_back(mk(3, 3)); rq.push_back(mk(4, 4));
    cmd(1, 2'b10, 3, 2, 0, 1'b0);
    wait_done("post_abort_scan", 100, cyc);
    check("post_abort_cycles", cyc, 5);
    check("post_abort_reads_left", rq.size(), 0);

    // two-cycle read latency on dut2
    cmd(2, 2'b10, 7, 1, 0, 1'b0);
    rv_cyc = 0; done_cyc = 0; rv_cnt = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      if (k == 1) check("lat2_ram_address", int'(ram_address2), 7);
      if (rd_valid2) begin
        rv_cnt++;
        if (rv_cyc == 0) begin
          rv_cyc = k;
          check("lat2_rd_addr", int'(rd_addr2), 7);
          check("lat2_rd_data", int'(rd_data2), 5);
        end
      end
      if (done2 && done_cyc == 0) done_cyc = k;
    end
    check("lat2_rd_valid_cycle", rv_cyc, 4);
    check("lat2_done_cycle", done_cyc, 5);
    check("lat2_rd_valid_count", rv_cnt, 1);

    check("final_writes_left", wq.size(), 0);
    check("final_reads_left", rq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
